// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO with one-cycle read latency
// into a valid/ready stream, with frame delimiting and a 3-entry skid buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beats_sent
);

  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] r_buf [3];
  logic [1:0]            r_wptr;
  logic [1:0]            r_rptr;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [CNT_WIDTH-1:0]  r_beats_sent;

  logic       w_credit_ok;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_wptr_nxt;
  logic [1:0] w_rptr_nxt;

  // Read issue and stream outputs; the credit check never looks at m_ready.
  always_comb begin
    w_credit_ok = (({1'b0, r_occ} + {2'b00, r_inflight}) <= 3'd2);
    fifo_rd_en  = !rst && en && !fifo_empty && w_credit_ok;
    m_valid     = (r_occ != 2'd0);
    m_data      = r_buf[r_rptr];
    m_last      = m_valid && (r_beat_cnt == LAST_BEAT);
    beats_sent  = r_beats_sent;
    w_push      = r_inflight;
    w_pop       = m_valid && m_ready;
    w_wptr_nxt  = (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
    w_rptr_nxt  = (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
  end

  // Track the read issued last cycle; its data arrives this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  // Skid buffer storage and write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
      r_wptr <= '0;
    end else if (w_push) begin
      r_buf[r_wptr] <= fifo_dout;
      r_wptr        <= w_wptr_nxt;
    end
  end

  // Read pointer and occupancy; simultaneous push and pop leaves occ unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_pop) begin
        r_rptr <= w_rptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Frame position and accepted-beat counter advance on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt   <= '0;
      r_beats_sent <= '0;
    end else if (w_pop) begin
      r_beats_sent <= r_beats_sent + CNT_WIDTH'(1);
      r_beat_cnt   <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + BEAT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and
// accepted beats are scored against the pushed word order and frame position.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_rd_en;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [3:0] beats_sent;

  int vectors    = 0;
  int miscompares = 0;

  // FIFO contents and expected stream order
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         tot;
  int         cyc;
  int         base;

  // Per-cycle log
  logic       lv[$];
  logic       lr[$];
  logic       ll[$];
  logic       lrd[$];
  logic [7:0] ld[$];
  logic [3:0] lbs[$];

  // Accepted beats with model expectations
  logic [7:0] acc_d[$];
  logic [7:0] acc_x[$];
  logic       acc_l[$];
  logic       acc_xl[$];
  int         acc_c[$];
  int         acc_miss;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH(8),
    .FRAME_LEN (4),
    .CNT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .beats_sent(beats_sent)
  );

  task automatic clear_log();
    lv.delete(); lr.delete(); ll.delete(); lrd.delete(); ld.delete(); lbs.delete();
    acc_d.delete(); acc_x.delete(); acc_l.delete(); acc_xl.delete(); acc_c.delete();
    acc_miss = 0;
    base = cyc;
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: drive inputs at negedge, sample, advance the FIFO model.
  task automatic tick(input logic r, input logic e, input logic rdy);
    logic [7:0] nd;
    logic       pend;
    @(negedge clk);
    rst = r; en = e; m_ready = rdy;
    #1;
    lv.push_back(m_valid); lr.push_back(m_ready); ll.push_back(m_last);
    lrd.push_back(fifo_rd_en); ld.push_back(m_data); lbs.push_back(beats_sent);
    pend = fifo_rd_en;
    nd   = fifo_dout;
    if (r) begin
      // Whatever the FIFO still holds is what the stream delivers next.
      exp_q = fq;
      tot   = 0;
    end else begin
      if (m_valid && m_ready) begin
        acc_d.push_back(m_data);
        acc_l.push_back(m_last);
        acc_c.push_back(cyc);
        acc_xl.push_back((tot % 4) == 3);
        if (exp_q.size() > 0) acc_x.push_back(exp_q.pop_front());
        else begin acc_x.push_back(8'h00); acc_miss++; end
        tot++;
      end
      if (fifo_rd_en && fq.size() > 0) nd = fq.pop_front();
    end
    cyc++;
    @(posedge clk);
    #1;
    if (pend) fifo_dout = nd;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    int fr;
    int fv;
    clear_log();
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      if (lv[i] !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", lv[i]); end
      vectors++;
      if (lrd[i] !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %0b want 0", lrd[i]); end
      vectors++;
      if (lbs[i] !== 4'd0) begin miscompares++; $display("FAIL reset_beats: got %0d want 0", lbs[i]); end
      vectors++;
      if (ld[i] !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %0h want 0", ld[i]); end
      vectors++;
      if (ll[i] !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %0b want 0", ll[i]); end
      vectors++;
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1);
    fr = -1; fv = -1;
    for (int i = 2; i < lv.size(); i++) begin
      if (fr < 0 && lrd[i]) fr = i;
      if (fv < 0 && lv[i]) fv = i;
    end
    if (fr !== 2) begin miscompares++; $display("FAIL reset_first_read: got idx %0d want 2", fr); end
    vectors++;
    if (fv - fr !== 2) begin miscompares++; $display("FAIL reset_latency: got %0d want 2", fv - fr); end
    vectors++;
    if (acc_d.size() !== 4) begin miscompares++; $display("FAIL reset_count: got %0d want 4", acc_d.size()); end
    vectors++;
    for (int i = 0; i < acc_d.size(); i++) begin
      if (acc_d[i] !== 8'h11 + 8'(i)) begin miscompares++; $display("FAIL reset_word%0d: got %0h want %0h", i, acc_d[i], 8'h11 + 8'(i)); end
      vectors++;
    end
    if (beats_sent !== 4'd4) begin miscompares++; $display("FAIL reset_beats_after: got %0d want 4", beats_sent); end
    vectors++;
  endtask

  task automatic test_streaming();
    clear_log();
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b1, 1'b1);
    if (acc_d.size() !== 8) begin miscompares++; $display("FAIL stream_count: got %0d want 8", acc_d.size()); end
    vectors++;
    for (int i = 0; i < acc_d.size(); i++) begin
      if (acc_d[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL stream_word%0d: got %0h want %0h", i, acc_d[i], i + 1); end
      vectors++;
      if (acc_l[i] !== (i == 3 || i == 7)) begin miscompares++; $display("FAIL stream_last%0d: got %0b want %0b", i, acc_l[i], (i == 3 || i == 7)); end
      vectors++;
      if (acc_c[i] !== acc_c[0] + i) begin miscompares++; $display("FAIL stream_gap%0d: got cycle %0d want %0d", i, acc_c[i], acc_c[0] + i); end
      vectors++;
    end
    if (beats_sent !== 4'(tot)) begin miscompares++; $display("FAIL stream_beats: got %0d want %0d", beats_sent, 4'(tot)); end
    vectors++;
  endtask

  task automatic test_backpressure();
    logic [7:0] w[6];
    int         pulses;
    int         fv;
    clear_log();
    for (int i = 0; i < 6; i++) begin w[i] = 8'($urandom); push(w[i]); end
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
    pulses = 0; fv = -1;
    for (int i = 0; i < 10; i++) begin
      if (lrd[i]) pulses++;
      if (fv < 0 && lv[i]) fv = i;
    end
    if (pulses !== 3) begin miscompares++; $display("FAIL bp_reads: got %0d want 3", pulses); end
    vectors++;
    if (fv !== 2) begin miscompares++; $display("FAIL bp_first_valid: got idx %0d want 2", fv); end
    vectors++;
    for (int i = 2; i < 10; i++) begin
      if (lv[i] !== 1'b1 || ld[i] !== w[0]) begin
        miscompares++; $display("FAIL bp_hold%0d: got v=%0b d=%0h want v=1 d=%0h", i, lv[i], ld[i], w[0]);
      end
      vectors++;
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b1);
    if (acc_c.size() < 1 || acc_c[0] - base !== 10) begin miscompares++; $display("FAIL bp_release_flow: first accept not at release cycle"); end
    vectors++;
    if (lrd[10] !== 1'b0 || lrd[11] !== 1'b1) begin miscompares++; $display("FAIL bp_refill: got %0b%0b want 01", lrd[10], lrd[11]); end
    vectors++;
    if (acc_d.size() !== 6) begin miscompares++; $display("FAIL bp_count: got %0d want 6", acc_d.size()); end
    vectors++;
    for (int i = 0; i < acc_d.size() && i < 6; i++) begin
      if (acc_d[i] !== w[i]) begin miscompares++; $display("FAIL bp_word%0d: got %0h want %0h", i, acc_d[i], w[i]); end
      vectors++;
      if (acc_l[i] !== acc_xl[i]) begin miscompares++; $display("FAIL bp_last%0d: got %0b want %0b", i, acc_l[i], acc_xl[i]); end
      vectors++;
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] w0;
    logic [7:0] w1;
    clear_log();
    w0 = 8'($urandom); w1 = 8'($urandom);
    push(w0); push(w1);
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1);
    if (lrd[0] !== 1'b1) begin miscompares++; $display("FAIL en_first_read: got %0b want 1", lrd[0]); end
    vectors++;
    for (int i = 1; i <= 6; i++) begin
      if (lrd[i] !== 1'b0) begin miscompares++; $display("FAIL en_no_read%0d: got %0b want 0", i, lrd[i]); end
      vectors++;
    end
    if (acc_d.size() !== 1 || acc_d[0] !== w0) begin miscompares++; $display("FAIL en_inflight: got %0d beats want 1 of %0h", acc_d.size(), w0); end
    vectors++;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1);
    if (lrd[7] !== 1'b1) begin miscompares++; $display("FAIL en_resume: got %0b want 1", lrd[7]); end
    vectors++;
    if (acc_d.size() !== 2 || acc_d[1] !== w1) begin miscompares++; $display("FAIL en_next_word: got %0d beats want 2 ending %0h", acc_d.size(), w1); end
    vectors++;
  endtask

  task automatic test_alt_ready();
    int n;
    clear_log();
    n = 0;
    push(8'($urandom)); push(8'($urandom));
    for (int i = 0; i < 13; i++) begin tick(1'b0, 1'b1, n[0]); n++; end
    for (int i = 0; i < 5; i++) push(8'($urandom));
    for (int i = 0; i < 20; i++) begin tick(1'b0, 1'b1, n[0]); n++; end
    drain();
    if (acc_d.size() !== 7 || acc_miss !== 0) begin miscompares++; $display("FAIL alt_count: got %0d want 7", acc_d.size()); end
    vectors++;
    for (int i = 0; i < acc_d.size(); i++) begin
      if (acc_d[i] !== acc_x[i]) begin miscompares++; $display("FAIL alt_word%0d: got %0h want %0h", i, acc_d[i], acc_x[i]); end
      vectors++;
    end
    if (acc_l.size() >= 4 && (acc_l[0] | acc_l[1] | acc_l[2] | !acc_l[3]) !== 1'b0) begin
      miscompares++; $display("FAIL alt_frame: got lasts %0b%0b%0b%0b want 0001", acc_l[0], acc_l[1], acc_l[2], acc_l[3]);
    end
    vectors++;
    for (int i = 0; i + 1 < lv.size(); i++) begin
      if (lv[i] && !lr[i]) begin
        if (lv[i+1] !== 1'b1 || ld[i+1] !== ld[i] || ll[i+1] !== ll[i]) begin
          miscompares++; $display("FAIL alt_stable%0d: got v=%0b d=%0h want v=1 d=%0h", i + 1, lv[i+1], ld[i+1], ld[i]);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_random();
    clear_log();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 8) push(8'($urandom));
      tick(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    drain();
    if (exp_q.size() !== 0 || acc_miss !== 0) begin miscompares++; $display("FAIL rand_loss: got %0d left %0d extra want 0 0", exp_q.size(), acc_miss); end
    vectors++;
    for (int i = 0; i < acc_d.size(); i++) begin
      if (acc_d[i] !== acc_x[i] || acc_l[i] !== acc_xl[i]) begin
        miscompares++; $display("FAIL rand_beat%0d: got %0h/%0b want %0h/%0b", i, acc_d[i], acc_l[i], acc_x[i], acc_xl[i]);
      end
      vectors++;
    end
    for (int i = 0; i + 1 < lv.size(); i++) begin
      if (lv[i] && !lr[i]) begin
        if (lv[i+1] !== 1'b1 || ld[i+1] !== ld[i] || ll[i+1] !== ll[i]) begin
          miscompares++; $display("FAIL rand_stable%0d: got v=%0b d=%0h want v=1 d=%0h", i + 1, lv[i+1], ld[i+1], ld[i]);
        end
        vectors++;
      end
    end
    if (beats_sent !== 4'(tot)) begin miscompares++; $display("FAIL rand_beats: got %0d want %0d", beats_sent, 4'(tot)); end
    vectors++;
  endtask

  task automatic test_midstream_reset();
    int k;
    clear_log();
    push(8'($urandom));
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) push(8'($urandom));
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    fq.delete();
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    k = lv.size() - 1;
    if (lv[k] !== 1'b0) begin miscompares++; $display("FAIL mrst_valid: got %0b want 0", lv[k]); end
    vectors++;
    if (lbs[k] !== 4'd0) begin miscompares++; $display("FAIL mrst_beats: got %0d want 0", lbs[k]); end
    vectors++;
    if (lrd[k] !== 1'b0) begin miscompares++; $display("FAIL mrst_rd_en: got %0b want 0", lrd[k]); end
    vectors++;
    for (int i = 0; i < 17; i++) push(8'($urandom));
    drain();
    if (acc_d.size() !== 18 || acc_miss !== 0) begin miscompares++; $display("FAIL mrst_count: got %0d want 18", acc_d.size()); end
    vectors++;
    for (int i = 1; i < acc_d.size(); i++) begin
      if (acc_d[i] !== acc_x[i] || acc_l[i] !== acc_xl[i]) begin
        miscompares++; $display("FAIL mrst_beat%0d: got %0h/%0b want %0h/%0b", i, acc_d[i], acc_l[i], acc_x[i], acc_xl[i]);
      end
      vectors++;
    end
    if (acc_l.size() >= 5 && (acc_l[1] !== 1'b0 || acc_l[4] !== 1'b1)) begin
      miscompares++; $display("FAIL mrst_frame: got %0b..%0b want 0..1", acc_l[1], acc_l[4]);
    end
    vectors++;
    if (beats_sent !== 4'd1) begin miscompares++; $display("FAIL mrst_wrap: got %0d want 1", beats_sent); end
    vectors++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    tot = 0; cyc = 0; base = 0; acc_miss = 0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    drain();
    test_enable_drop();
    test_alt_ready();
    test_random();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
